// File: rtl/beverage_pkg.sv
// Shared definitions for the beverage dispenser: drink codes, price/recipe tables, FSM states.
package beverage_pkg;

  typedef enum logic [2:0] {
    ESPRESSO   = 3'd0,
    AMERICANO  = 3'd1,
    CAPPUCCINO = 3'd2,
    MOCHA      = 3'd3,
    CHOCOLATE  = 3'd4
  } drink_e;

  localparam int unsigned NumRecipes = 5;

  // Indexed by drink_e.
  localparam int unsigned PriceTable [NumRecipes] = '{300, 400, 500, 600, 400};

  // Mask bits {water, coffee, milk, chocolate, sugar}; water is dispensed first.
  localparam logic [4:0] RecipeTable [NumRecipes] = '{
    5'b11000, 5'b11001, 5'b11101, 5'b11111, 5'b10111
  };

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDispense = 2'd1;
  localparam logic [1:0] StDone     = 2'd2;

  function automatic int unsigned price_of(int unsigned code);
    if (code < NumRecipes) return PriceTable[code[2:0]];
    return 0;
  endfunction

  function automatic logic [4:0] recipe_of(int unsigned code);
    if (code < NumRecipes) return RecipeTable[code[2:0]];
    return 5'b00000;
  endfunction

  // One-hot of the highest set bit (the next valve in dispensing order).
  function automatic logic [4:0] first_valve(logic [4:0] m);
    logic [4:0] r;
    r = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) r = 5'b00001 << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/recipe_sequencer.sv
// Walks a 5-bit recipe mask from MSB to LSB, holding each selected valve open for STEP_CYCLES.
module recipe_sequencer
  import beverage_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] mask,
  output logic [4:0] valves,
  output logic       done
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

  logic [4:0]      valves_q, valves_d;
  logic [4:0]      remain_q, remain_d;
  logic [CntW-1:0] count_q, count_d;
  logic [4:0]      nxt;

  always_comb begin
    valves_d = valves_q;
    remain_d = remain_q;
    count_d  = count_q;
    nxt      = first_valve(start ? mask : remain_q);
    if (start) begin
      valves_d = nxt;
      remain_d = mask & ~nxt;
      count_d  = CntLast;
    end else if (valves_q != 5'b00000) begin
      if (count_q == '0) begin
        valves_d = nxt;
        remain_d = remain_q & ~nxt;
        count_d  = CntLast;
      end else begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valves_q <= 5'b00000;
      remain_q <= 5'b00000;
      count_q  <= '0;
    end else begin
      valves_q <= valves_d;
      remain_q <= remain_d;
      count_q  <= count_d;
    end
  end

  // High during the final cycle of the final valve.
  assign done   = (valves_q != 5'b00000) && (count_q == '0) && (remain_q == 5'b00000);
  assign valves = valves_q;

endmodule

// File: rtl/beverage_dispenser.sv
// Coin-operated drink controller: credit counting, price check, recipe dispensing, change return.
// Optional refund-on-cancel is enabled by defining CANCEL_REFUND_EN.
module beverage_dispenser
  import beverage_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 10,
  parameter int unsigned COIN_LO_VAL = 100,
  parameter int unsigned COIN_HI_VAL = 500,
  parameter int unsigned MAX_CREDIT  = 1000,
  parameter int unsigned NUM_DRINKS  = 5,
  parameter int unsigned TYPE_W      = 3,
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_lo_n,
  input  logic                coin_hi_n,
  input  logic [TYPE_W-1:0]   drink_type,
  input  logic                confirm,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                denied,
  output logic                busy,
  output logic                water,
  output logic                coffee,
  output logic                milk,
  output logic                chocolate,
  output logic                sugar,
  output logic                finished
);

  if ((2 ** CREDIT_W) <= MAX_CREDIT) begin : g_credit_w_chk
    $error("CREDIT_W too narrow to hold MAX_CREDIT");
  end
  if ((2 ** TYPE_W) < NUM_DRINKS) begin : g_type_w_chk
    $error("TYPE_W too narrow to encode NUM_DRINKS");
  end

  localparam int unsigned SumW = CREDIT_W + 2;
  localparam logic [SumW-1:0] LoVal = SumW'(COIN_LO_VAL);
  localparam logic [SumW-1:0] HiVal = SumW'(COIN_HI_VAL);
  localparam logic [SumW-1:0] MaxCr = SumW'(MAX_CREDIT);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                denied_q, denied_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                lo_q, hi_q, confirm_q;

  logic                lo_edge, hi_edge, confirm_edge;
  logic [SumW-1:0]     coin_sum, coin_total;
  logic                coin_over;
  logic [CREDIT_W-1:0] coin_add, price;
  logic                code_ok;
  logic                seq_start, seq_done;
  logic [4:0]          valves;

  assign lo_edge      = lo_q & ~coin_lo_n;
  assign hi_edge      = hi_q & ~coin_hi_n;
  assign confirm_edge = confirm & ~confirm_q;

  // Simultaneous coins are accepted or rejected together.
  assign coin_sum   = (lo_edge ? LoVal : '0) + (hi_edge ? HiVal : '0);
  assign coin_total = {2'b00, credit_q} + coin_sum;
  assign coin_over  = (coin_sum != '0) && (coin_total > MaxCr);
  assign coin_add   = coin_over ? '0 : coin_sum[CREDIT_W-1:0];

  assign code_ok = 32'(drink_type) < NUM_DRINKS;
  assign price   = CREDIT_W'(price_of(32'(drink_type)));

`ifdef CANCEL_REFUND_EN
  logic cancel_q;
  logic cancel_edge;
  assign cancel_edge = cancel & ~cancel_q;
  always_ff @(posedge clock) cancel_q <= cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = change_q;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    denied_d       = 1'b0;
    finished_d     = 1'b0;
    seq_start      = 1'b0;
    case (state_q)
      StIdle: begin
        coin_reject_d = coin_over;
        credit_d      = credit_q + coin_add;
`ifdef CANCEL_REFUND_EN
        if (cancel_edge && (credit_q != '0)) begin
          change_d       = credit_q + coin_add;
          change_valid_d = 1'b1;
          credit_d       = '0;
        end else
`endif
        if (confirm_edge) begin
          // Price check uses the credit held before any same-cycle coin.
          if (code_ok && (credit_q >= price)) begin
            credit_d  = credit_q - price + coin_add;
            seq_start = 1'b1;
            state_d   = StDispense;
          end else begin
            denied_d = 1'b1;
          end
        end
      end
      StDispense: begin
        if (seq_done) begin
          state_d        = StDone;
          finished_d     = 1'b1;
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Edge registers track the inputs in reset too, so held buttons are not counted on release.
  always_ff @(posedge clock) begin
    lo_q      <= coin_lo_n;
    hi_q      <= coin_hi_n;
    confirm_q <= confirm;
    if (reset) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      denied_q       <= 1'b0;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      denied_q       <= denied_d;
      busy_q         <= busy_d;
      finished_q     <= finished_d;
    end
  end

  recipe_sequencer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_seq (
    .clock  (clock),
    .reset  (reset),
    .start  (seq_start),
    .mask   (recipe_of(32'(drink_type))),
    .valves (valves),
    .done   (seq_done)
  );

  assign credit       = credit_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;
  assign denied       = denied_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign water        = valves[4];
  assign coffee       = valves[3];
  assign milk         = valves[2];
  assign chocolate    = valves[1];
  assign sugar        = valves[0];

endmodule

// File: tb/tb_beverage_dispenser.sv
// Self-checking bench for beverage_dispenser: per-cycle model comparison plus directed literals.
module tb_beverage_dispenser;

  localparam int StepCycles = 4;
  localparam int Mark       = 32;
`ifdef CANCEL_REFUND_EN
  localparam bit CancelEn = 1'b1;
`else
  localparam bit CancelEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_lo_n = 1'b1, coin_hi_n = 1'b1, confirm = 1'b0, cancel = 1'b0;
  logic [2:0] drink_type = 3'd0;
  logic [9:0] credit, change;
  logic       change_valid, coin_reject, denied, busy, finished;
  logic       water, coffee, milk, chocolate, sugar;

  beverage_dispenser #(
    .CREDIT_W(10), .COIN_LO_VAL(100), .COIN_HI_VAL(500), .MAX_CREDIT(1000),
    .NUM_DRINKS(5), .TYPE_W(3), .STEP_CYCLES(StepCycles)
  ) dut (
    .clock(clock), .reset(reset), .coin_lo_n(coin_lo_n), .coin_hi_n(coin_hi_n),
    .drink_type(drink_type), .confirm(confirm), .cancel(cancel), .credit(credit),
    .change(change), .change_valid(change_valid), .coin_reject(coin_reject),
    .denied(denied), .busy(busy), .water(water), .coffee(coffee), .milk(milk),
    .chocolate(chocolate), .sugar(sugar), .finished(finished)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Model: credit as an integer, dispensing as a queue of per-cycle valve vectors.
  int         prices  [5] = '{300, 400, 500, 600, 400};
  logic [4:0] recipes [5] = '{5'b11000, 5'b11001, 5'b11101, 5'b11111, 5'b10111};
  int         vq[$];
  int         m_credit = 0;
  bit         m_valid = 1'b0, m_done = 1'b0;
  logic       p_lo, p_hi, p_cf, p_cn;
  int         e_credit = 0, e_change = 0;
  bit         e_cv, e_rej, e_den, e_busy, e_fin;
  logic [4:0] e_valves = 5'b0;

  int valve_cnt [5];
  int fin_cnt = 0, den_cnt = 0, rej_cnt = 0, cv_cnt = 0, last_change = -1;

  always begin : model
    int  coin, add, idx, ent;
    bit  lo_e, hi_e, cf_e, cn_e;
    @(posedge clock);
    e_cv = 0; e_rej = 0; e_den = 0; e_fin = 0;
    if (reset) begin
      m_valid = 1'b1; m_credit = 0; vq.delete(); m_done = 1'b0;
      e_busy = 0; e_valves = 5'b0;
    end else if (m_done) begin
      m_done = 1'b0; e_busy = 0;
    end else if (vq.size() != 0) begin
      ent = vq.pop_front();
      if (ent == Mark) begin
        e_fin = 1; e_cv = 1; e_change = m_credit; m_credit = 0; e_valves = 5'b0; m_done = 1'b1;
      end else begin
        e_valves = 5'(ent);
      end
    end else begin
      lo_e = p_lo && !coin_lo_n;
      hi_e = p_hi && !coin_hi_n;
      cf_e = !p_cf && confirm;
      cn_e = !p_cn && cancel;
      coin = (lo_e ? 100 : 0) + (hi_e ? 500 : 0);
      add  = 0;
      if (coin != 0) begin
        if (m_credit + coin <= 1000) add = coin;
        else e_rej = 1;
      end
      idx = int'(drink_type);
      if (CancelEn && cn_e && m_credit > 0) begin
        e_change = m_credit + add; e_cv = 1; m_credit = 0;
      end else if (cf_e) begin
        if (idx >= 5 || m_credit < prices[idx]) begin
          e_den = 1; m_credit += add;
        end else begin
          m_credit = m_credit - prices[idx] + add;
          for (int b = 4; b >= 0; b--)
            if (recipes[idx][b]) for (int s = 0; s < StepCycles; s++) vq.push_back(1 << b);
          vq.push_back(Mark);
          e_valves = 5'(vq.pop_front());
          e_busy   = 1;
        end
      end else begin
        m_credit += add;
      end
    end
    e_credit = m_credit;
    p_lo = coin_lo_n; p_hi = coin_hi_n; p_cf = confirm; p_cn = cancel;
    #1;
    if (m_valid) begin
      check("credit", int'(credit), e_credit);
      check("valves", int'({water, coffee, milk, chocolate, sugar}), int'(e_valves));
      check("busy", int'(busy), int'(e_busy));
      check("finished", int'(finished), int'(e_fin));
      check("change_valid", int'(change_valid), int'(e_cv));
      check("coin_reject", int'(coin_reject), int'(e_rej));
      check("denied", int'(denied), int'(e_den));
      if (e_cv) check("change", int'(change), e_change);
      if (water) valve_cnt[4]++;
      if (coffee) valve_cnt[3]++;
      if (milk) valve_cnt[2]++;
      if (chocolate) valve_cnt[1]++;
      if (sugar) valve_cnt[0]++;
      if (finished) fin_cnt++;
      if (denied) den_cnt++;
      if (coin_reject) rej_cnt++;
      if (change_valid) begin cv_cnt++; last_change = int'(change); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic press_lo();
    coin_lo_n = 1'b0; tick(1); coin_lo_n = 1'b1; tick(1);
  endtask
  task automatic press_hi();
    coin_hi_n = 1'b0; tick(1); coin_hi_n = 1'b1; tick(1);
  endtask
  task automatic do_confirm(input logic [2:0] t);
    drink_type = t; confirm = 1'b1; tick(1); confirm = 1'b0; tick(1);
  endtask
  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
  endtask
  task automatic clear_mon();
    for (int i = 0; i < 5; i++) valve_cnt[i] = 0;
    fin_cnt = 0; den_cnt = 0; rej_cnt = 0; cv_cnt = 0; last_change = -1;
  endtask
  function automatic int all_valves();
    return valve_cnt[0] + valve_cnt[1] + valve_cnt[2] + valve_cnt[3] + valve_cnt[4];
  endfunction

  initial begin
    // Button held through reset must not count on release.
    coin_lo_n = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    coin_lo_n = 1'b1;
    tick(2);
    check("reset credit", int'(credit), 0);
    check("reset busy", int'(busy), 0);

    // 1: espresso at 600.
    clear_mon();
    press_hi(); press_lo();
    check("t1 credit before", int'(credit), 600);
    do_confirm(3'd0);
    check("t1 credit after accept", int'(credit), 300);
    tick(12);
    check("t1 water cycles", valve_cnt[4], 4);
    check("t1 coffee cycles", valve_cnt[3], 4);
    check("t1 finished", fin_cnt, 1);
    check("t1 change", last_change, 300);
    check("t1 credit end", int'(credit), 0);

    // 2: cappuccino with 100 credit.
    clear_mon();
    press_lo();
    do_confirm(3'd2);
    tick(2);
    check("t2 denied", den_cnt, 1);
    check("t2 credit", int'(credit), 100);
    check("t2 valves", all_valves(), 0);
    do_confirm(3'd7);
    check("t2 invalid code denied", den_cnt, 2);
    do_reset();

    // 3: credit ceiling.
    clear_mon();
    press_hi(); press_lo(); press_hi();
    check("t3 reject", rej_cnt, 1);
    check("t3 credit held", int'(credit), 600);
    repeat (4) press_lo();
    check("t3 credit max", int'(credit), 1000);
    press_lo();
    check("t3 reject at max", rej_cnt, 2);
    do_reset();

    // 4: both coins in one cycle.
    coin_lo_n = 1'b0; coin_hi_n = 1'b0; tick(1);
    coin_lo_n = 1'b1; coin_hi_n = 1'b1; tick(1);
    check("t4 both coins", int'(credit), 600);

    // 5: mocha, full run, with a coin ignored mid-dispense.
    clear_mon();
    do_confirm(3'd3);
    tick(3);
    press_lo();
    tick(20);
    check("t5 valve cycles", all_valves(), 20);
    check("t5 sugar cycles", valve_cnt[0], 4);
    check("t5 change", last_change, 0);
    check("t5 change pulses", cv_cnt, 1);

    // 5b: reset during the milk step.
    press_hi(); press_lo();
    do_confirm(3'd3);
    for (int i = 0; i < 40 && !milk; i++) tick(1);
    check("t5 reached milk", int'(milk), 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("t5 outputs after reset",
          int'({water, coffee, milk, chocolate, sugar, busy, finished, change_valid}), 0);
    check("t5 credit after reset", int'(credit), 0);
    tick(2);

    // Coin arriving with the confirm edge.
    clear_mon();
    press_hi();
    coin_lo_n = 1'b0; drink_type = 3'd0; confirm = 1'b1; tick(1);
    coin_lo_n = 1'b1; confirm = 1'b0; tick(1);
    check("coin+confirm credit", int'(credit), 300);
    tick(10);
    check("coin+confirm change", last_change, 300);

    // 6: cancel and confirm together.
    clear_mon();
    press_hi();
    drink_type = 3'd0; cancel = 1'b1; confirm = 1'b1; tick(1);
    cancel = 1'b0; confirm = 1'b0; tick(12);
`ifdef CANCEL_REFUND_EN
    check("t6 refund", last_change, 500);
    check("t6 no finished", fin_cnt, 0);
    check("t6 no valves", all_valves(), 0);
`else
    check("t6 dispensed", fin_cnt, 1);
    check("t6 change", last_change, 200);
    check("t6 water cycles", valve_cnt[4], 4);
`endif
    check("t6 credit end", int'(credit), 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
